mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide responder for the MIPS multicycle datapath. It accepts one-cycle start pulses from the control unit (MULTcontrol / DIVcontrol), iterates over the latched A/B operands, and holds the 64-bit result in internal HI/LO registers read by MFHI/MFLO. It also flags division by zero (Div0) back to the control unit. It returns `done` so the control FSM can wait in its MULT/DIV state instead of advancing blindly.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- mult_start  in  1  one-cycle pulse from MULTcontrol; begin signed A*B.
- div_start  in  1  one-cycle pulse from DIVcontrol; begin signed A/B.
- a  in  WIDTH  operand A (rs), sampled only on the accepting edge.
- b  in  WIDTH  operand B (rt), sampled only on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; HI/LO (or div0) valid this cycle.
- div0  out  1  one-cycle pulse with done on divide by zero (macro-dependent).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on the edge where mult_start or div_start is sampled high:
  - latch |a|, |b|, the sign bits and the op type;
  - clear the iteration counter and enter RUN.
  - If both starts are high, mult wins and div_start is dropped.
- RUN, multiply: radix-2 shift-add on magnitudes; 64-bit partial product; one bit per cycle.
- RUN, divide: restoring division on magnitudes; quotient shifted in one bit per cycle; remainder held WIDTH+1 bits.
- RUN exits to FIX after ITER cycles; the counter runs 0..ITER-1 and is 6 bits.
- FIX: apply sign correction and write HI/LO; go to DONE.
  - mult: if sign(a) xor sign(b), negate the 64-bit product. hi = [63:32], lo = [31:0].
  - div: lo = quotient, negated if sign(a) xor sign(b). hi = remainder, negated if sign(a).
  - Division truncates toward zero.
- DONE: done=1 for one cycle, then IDLE.
- Start pulses in RUN, FIX or DONE are ignored (not queued).
- hi/lo hold their value across idle periods and are written only in FIX.
- Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 with no flag.
- Reset outputs: busy=0, done=0, div0=0, hi=0, lo=0; state=IDLE.
- Reset asserted mid-operation aborts immediately; no done is produced.

## Timing
- Start sampled high in cycle 0.
- RUN occupies cycles 1..32; FIX is cycle 33; done=1 in cycle 34. Latency is 34 cycles start-to-done.
- busy=1 in cycles 1..33, and 0 in DONE.
- A new start is accepted at the earliest in cycle 35, i.e. once back in IDLE. A start that is high during DONE is ignored.
- hi/lo change at the end of cycle 33 and are stable from cycle 34 on.
- done and div0 are registered outputs.

## Configuration
- MULTDIV_DIV0_EN defined:
  - div_start with b==0 goes IDLE→DONE directly.
  - done=1 and div0=1 in cycle 1; busy stays 0.
  - hi/lo are unchanged.
- MULTDIV_DIV0_EN undefined:
  - div0 is tied to 0.
  - Divide by zero runs the full 34 cycles through the normal algorithm.
  - Result: lo=0xFFFFFFFF and hi=a if a>=0; lo=0x00000001 and hi=a if a<0.

## Test plan
- Multiply: a=0xFFFFFFFD (-3), b=7, mult_start pulse -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1..33.
- Divide: a=0xFFFFFFF9 (-7), b=2, div_start -> done in cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Divide by zero: a=5, b=0.
  - With MULTDIV_DIV0_EN: done=div0=1 in cycle 1; hi/lo keep prior values.
  - Without it: done in cycle 34, lo=0xFFFFFFFF, hi=5, div0=0.
- Start collisions: mult_start and div_start high together with a=0x10000, b=0x10000 -> multiply performed, hi=1, lo=0. A second mult_start pulse in cycle 10 is ignored; exactly one done occurs.
- Reset mid-operation: reset low in cycle 15 of a multiply -> busy, done, hi and lo go to 0 immediately. After release, a fresh mult 6*7 gives lo=42, hi=0 in 34 cycles.
- Extremes: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Signed multicycle multiply/divide unit with internal HI/LO registers (MIPS MULT/DIV).
// Latency: 34 cycles from accepted start to the done pulse; 1 cycle for a short-circuited divide by zero.
// Backpressure: none; starts arriving while busy or in the done cycle are dropped, not queued.
// Optional feature: define MULTDIV_DIV0_EN to short-circuit divide by zero and raise div0.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             op_mul_q, op_mul_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  // Magnitude operand kept for the whole run: |a| for multiply, |b| for divide.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // Multiply: upper half of the partial product. Divide: partial remainder.
  logic [WIDTH:0]   rem_q, rem_d;
  // Multiply: multiplier shifting out / product low half shifting in.
  // Divide: dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MULTDIV_DIV0_EN
  logic             div0_q, div0_d;
`endif

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; the most negative value maps onto itself, which is correct as unsigned.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Shift-add step: add the multiplicand into the upper half when the current multiplier bit is set.
  assign mul_sum = rem_q + (low_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide step: bring down the next dividend bit and try subtracting the divisor.
  assign div_sh   = {rem_q[WIDTH-1:0], low_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd_q});
  assign div_diff = div_sh - {1'b0, opnd_q};

  // Sign correction applied once the magnitude iteration is complete.
  assign prod_mag = {rem_q[WIDTH-1:0], low_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
  assign quo_fix  = (sa_q ^ sb_q) ? -low_q : low_q;
  assign rem_fix  = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_mul_d = op_mul_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    low_d    = low_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULTDIV_DIV0_EN
    div0_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (mult_start || div_start) begin
          // Multiply takes priority when both pulses collide.
          op_mul_d = mult_start;
          sa_d     = a[WIDTH-1];
          sb_d     = b[WIDTH-1];
          opnd_d   = mult_start ? abs_a : abs_b;
          low_d    = mult_start ? abs_b : abs_a;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
`ifdef MULTDIV_DIV0_EN
          if (!mult_start && (b == '0)) begin
            state_d = S_DONE;
            div0_d  = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        if (op_mul_q) begin
          rem_d = {1'b0, mul_sum[WIDTH:1]};
          low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end else begin
          rem_d = div_ge ? div_diff : div_sh;
          low_d = {low_q[WIDTH-2:0], div_ge};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIX: begin
        if (op_mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, HI/LO and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      rem_q    <= '0;
      low_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_mul_q <= op_mul_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      low_q    <= low_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef MULTDIV_DIV0_EN
  // Divide-by-zero flag, pulsed together with done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div0_q <= 1'b0;
    end else begin
      div0_q <= div0_d;
    end
  end

  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed operations plus a cycle-level reference model.
// Latency: expects done 34 cycles after an accepted start (1 cycle for a short-circuited divide by zero).
// Backpressure: none; the bench also drives starts while busy and expects them to be dropped.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit chk_on = 1'b0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset(reset),
    .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain signed arithmetic.
  function automatic void model_result(input bit is_mul, input logic [31:0] av, input logic [31:0] bv,
                                       output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (is_mul) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else if (bv == 32'h0) begin
      rh = av;
      rl = av[31] ? 32'h1 : 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end
  endfunction

  // Reference timing: cycle number since acceptance, end cycle, pending result.
  bit          m_active = 1'b0;
  bit          m_short = 1'b0;
  int          m_cyc = 0;
  int          m_end = 34;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_short  = 1'b0;
      m_cyc    = 0;
      m_hi     = '0;
      m_lo     = '0;
    end else if (m_active) begin
      if (m_cyc == m_end) begin
        m_active = 1'b0;
      end else begin
        m_cyc++;
        if (m_cyc == m_end && !m_short) begin
          m_hi = m_rhi;
          m_lo = m_rlo;
        end
      end
    end else if (mult_start || div_start) begin
      m_active = 1'b1;
      m_short  = 1'b0;
      m_cyc    = 1;
      m_end    = 34;
      model_result(mult_start, a, b, m_rhi, m_rlo);
`ifdef MULTDIV_DIV0_EN
      if (!mult_start && b == 32'h0) begin
        m_short = 1'b1;
        m_end   = 1;
      end
`endif
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("cyc_busy", busy, m_active && !m_short && (m_cyc < m_end));
      chk("cyc_done", done, m_active && (m_cyc == m_end));
      chk("cyc_div0", div0, m_active && m_short && (m_cyc == m_end));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
    if (done) done_cnt++;
  end

  // One operation with literal expectations on result, latency and busy duration.
  task automatic run_op(input string nm, input bit ms, input bit ds,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit ediv0, input int ebusy);
    int lat;
    int bcnt;
    @(negedge clock);
    a = av; b = bv; mult_start = ms; div_start = ds;
    @(negedge clock);
    mult_start = 1'b0; div_start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(ebusy));
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    chk({nm, "_div0"}, div0, ediv0);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] th, tl;
    int d0;

    // Pin the model itself against hand-computed results.
    model_result(1'b1, 32'hFFFF_FFFD, 32'd7, th, tl);
    chk("model_mul_hi", th, 32'hFFFF_FFFF);
    chk("model_mul_lo", tl, 32'hFFFF_FFEB);
    model_result(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, th, tl);
    chk("model_ovf_hi", th, 32'h0);
    chk("model_ovf_lo", tl, 32'h8000_0000);
    model_result(1'b0, 32'd5, 32'd0, th, tl);
    chk("model_dz_lo", tl, 32'hFFFF_FFFF);

    repeat (2) @(negedge clock);
    chk_on = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_div0", div0, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    #2 reset = 1'b1;

    run_op("mul_m3x7", 1, 0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 0, 33);
    run_op("div_m7d2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, 33);
    run_op("div_7dm2", 0, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 0, 33);
    run_op("div_m7dm2", 0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 34, 0, 33);
`ifdef MULTDIV_DIV0_EN
    run_op("div_5d0", 0, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd3, 1, 1, 0);
`else
    run_op("div_5d0", 0, 1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 34, 0, 33);
    run_op("div_m5d0", 0, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, 34, 0, 33);
`endif

    // Colliding starts: multiply wins; a later start while busy is dropped.
    d0 = done_cnt;
    @(negedge clock);
    a = 32'h0001_0000; b = 32'h0001_0000; mult_start = 1'b1; div_start = 1'b1;
    @(negedge clock);
    mult_start = 1'b0; div_start = 1'b0;
    repeat (9) @(negedge clock);
    a = 32'd3; b = 32'd3; mult_start = 1'b1;
    @(negedge clock);
    mult_start = 1'b0;
    repeat (40) @(negedge clock);
    chk("coll_done_count", 64'(done_cnt - d0), 64'd1);
    chk("coll_hi", hi, 32'd1);
    chk("coll_lo", lo, 32'd0);

    // Reset in cycle 15 of a multiply clears everything at once and suppresses done.
    @(negedge clock);
    a = 32'h0000_1234; b = 32'h0000_5678; mult_start = 1'b1;
    @(negedge clock);
    mult_start = 1'b0;
    repeat (14) @(negedge clock);
    chk("pre_rst_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clock);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

    run_op("mul_6x7", 1, 0, 32'd6, 32'd7, 32'd0, 32'd42, 34, 0, 33);
    run_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 0, 33);
    run_op("mul_min2", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34, 0, 33);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
